// File: rtl/lcd_pkg.sv
// Shared encodings for the LCD command dispatcher: image command codes and
// the dispatch state enum, also exported on the state_dbg port.
package lcd_pkg;

  localparam int CMD_W = 3;

  localparam logic [CMD_W-1:0] CMD_WRITE = 3'd0;
  localparam logic [CMD_W-1:0] CMD_UP    = 3'd1;
  localparam logic [CMD_W-1:0] CMD_DOWN  = 3'd2;
  localparam logic [CMD_W-1:0] CMD_LEFT  = 3'd3;
  localparam logic [CMD_W-1:0] CMD_RIGHT = 3'd4;
  localparam logic [CMD_W-1:0] CMD_AVG   = 3'd5;
  localparam logic [CMD_W-1:0] CMD_MIRX  = 3'd6;
  localparam logic [CMD_W-1:0] CMD_MIRY  = 3'd7;

  typedef enum logic [2:0] {
    WAIT_RDY,
    ISSUE,
    WAIT_HI,
    WAIT_LO,
    DONE_WAIT,
    DONE
  } dispatch_state_e;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous FIFO with an occupancy count and a flush that empties it in one cycle.
// Pushes while full and pops while empty are dropped. Flush wins over push and pop.
module lcd_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lcd_cmd_dispatch.sv
// Queues host image commands and issues them one at a time to the LCD controller,
// holding cmd through each busy period; flags busy timeouts and image completion.
module lcd_cmd_dispatch
  import lcd_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 127
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CMD_W-1:0]       host_cmd,
  input  logic                   host_valid,
  output logic                   host_ready,
  output logic [CMD_W-1:0]       cmd,
  output logic                   cmd_valid,
  input  logic                   busy,
  input  logic                   done,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [7:0]             issued_cnt,
  output logic                   image_done,
  output logic                   err,
  output dispatch_state_e        state_dbg
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_CNT = DEPTH[CW-1:0];
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  // Handshakes: a host push happens on any edge where host_valid && host_ready;
  // cmd_valid is a one-cycle strobe with no back-pressure, after which the
  // controller answers with a busy pulse, and cmd stays put until the next issue.
  dispatch_state_e  state;
  logic             hi_cnt;
  logic [TW-1:0]    lo_cnt;
  logic [CMD_W-1:0] head;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             flush;
  logic [CW-1:0]    count_next;
  logic             host_ready_next;

  assign push  = host_valid && host_ready;
  assign pop   = (state == WAIT_RDY) && !busy && !fifo_empty;
  // done may arrive together with busy falling after a write; both paths flush.
  assign flush = done && ((state == DONE_WAIT) ||
                          ((state == WAIT_LO) && !busy && (cmd == CMD_WRITE)));

  // host_ready is registered, so it is computed from next-cycle occupancy and state.
  assign count_next      = flush ? '0 : fifo_count + CW'(push) - CW'(pop);
  assign host_ready_next = !flush && (state != DONE) && (count_next != FULL_CNT);
  assign state_dbg       = state;

  lcd_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (host_cmd),
    .pop   (pop),
    .flush (flush),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= WAIT_RDY;
      cmd        <= '0;
      cmd_valid  <= 1'b0;
      issued_cnt <= '0;
      image_done <= 1'b0;
      err        <= 1'b0;
      host_ready <= 1'b0;
      hi_cnt     <= 1'b0;
      lo_cnt     <= '0;
    end else begin
      cmd_valid  <= 1'b0;
      host_ready <= host_ready_next;
      case (state)
        WAIT_RDY: begin
          if (pop) begin
            state     <= ISSUE;
            cmd       <= head;
            cmd_valid <= 1'b1;
            if (issued_cnt != 8'hFF) issued_cnt <= issued_cnt + 1'b1;
          end
        end
        ISSUE: begin
          state  <= WAIT_HI;
          hi_cnt <= 1'b0;
        end
        WAIT_HI: begin
          if (busy) begin
            state  <= WAIT_LO;
            lo_cnt <= '0;
          end else if (hi_cnt) begin
            err   <= 1'b1;
            state <= WAIT_RDY;
          end else begin
            hi_cnt <= 1'b1;
          end
        end
        WAIT_LO: begin
          if (!busy) begin
            if (cmd != CMD_WRITE) begin
              state <= WAIT_RDY;
            end else if (done) begin
              image_done <= 1'b1;
              state      <= DONE;
            end else begin
              state <= DONE_WAIT;
            end
          end else if (lo_cnt == TO_LAST) begin
            err   <= 1'b1;
            state <= WAIT_RDY;
          end else begin
            lo_cnt <= lo_cnt + 1'b1;
          end
        end
        DONE_WAIT: begin
          if (done) begin
            image_done <= 1'b1;
            state      <= DONE;
          end
        end
        DONE:    ;
        default: state <= WAIT_RDY;
      endcase
    end
  end

endmodule

// File: doc/lcd_cmd_dispatch.md
Name: lcd_cmd_dispatch

Overview:
- Command source directly upstream of the LCD image controller.
- Buffers 3-bit image commands from a host into a small FIFO.
- Issues them one at a time on the controller's cmd/cmd_valid/busy handshake, holding cmd stable while the controller executes.
- Reports completion after the Write command (0) finishes, and flags a controller that stops responding.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- TIMEOUT, 127, maximum cycles busy may stay high for one command before err sets.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- host_cmd  in  3  command to enqueue.
- host_valid  in  1  host_cmd valid this cycle.
- host_ready  out  1  FIFO can accept; push = host_valid & host_ready.
- cmd  out  3  command to the LCD controller.
- cmd_valid  out  1  one-cycle issue strobe to the LCD controller.
- busy  in  1  LCD controller busy.
- done  in  1  LCD controller write-back complete.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- issued_cnt  out  8  number of commands issued, saturating at 255.
- image_done  out  1  sticky; image write-back finished.
- err  out  1  sticky; busy timeout.

Behaviour:
- Reset (reset=0, asynchronous): state=WAIT_RDY, FIFO empty, fifo_count=0, host_ready=0, cmd=0, cmd_valid=0, issued_cnt=0, image_done=0, err=0.
- Reset asserted mid-command drops cmd_valid immediately; in-flight commands are lost.
- host_ready = (state != DONE) & (fifo_count != DEPTH). It does not account for a same-cycle pop, so there is no push when full.
- FIFO: push and pop in the same cycle leaves the count unchanged. There is no bypass: a push into an empty FIFO can issue at the earliest on the next cycle.
- All outputs are registered.
- WAIT_RDY:
  - Waits until busy==0. After reset, busy is unknown or 1 while the controller loads its image.
  - busy==0 & FIFO non-empty -> ISSUE.
- ISSUE (1 cycle):
  - Pops the head; cmd <= head; cmd_valid=1 for exactly this cycle; issued_cnt++ (saturating).
  - Next state WAIT_HI.
- WAIT_HI:
  - cmd held. busy==1 -> WAIT_LO.
  - busy still 0 after 2 cycles -> err=1, state WAIT_RDY.
- WAIT_LO:
  - cmd held stable; the controller reads cmd for the whole busy period.
  - Timeout counter increments each cycle; reaching TIMEOUT -> err=1, state WAIT_RDY.
  - When busy==0:
    - if cmd==0 -> DONE_WAIT;
    - else -> WAIT_RDY, and the next command may issue the following cycle.
  - Shift, average and mirror commands (1-7) give busy high for 1 cycle. Write (0) gives busy high for 64 cycles.
- DONE_WAIT:
  - done==1 sampled -> image_done=1, FIFO flushed (fifo_count=0), state DONE.
  - done==1 may coincide with busy falling; that is legal and handled in a single transition to DONE.
- DONE: terminal until reset; host_ready=0; pushes ignored; cmd_valid stays 0.
- err does not block operation; dispatch continues from WAIT_RDY.
- Commands queued behind a 0 are discarded at the DONE_WAIT flush.

Decomposition:
- Shared package lcd_pkg:
  - Command encodings: CMD_WRITE=0, CMD_UP=1, CMD_DOWN=2, CMD_LEFT=3, CMD_RIGHT=4, CMD_AVG=5, CMD_MIRX=6, CMD_MIRY=7.
  - Dispatch state enum: WAIT_RDY, ISSUE, WAIT_HI, WAIT_LO, DONE_WAIT, DONE.
- One sub-module: lcd_cmd_fifo, a synchronous FIFO with count, parameterised by DEPTH and WIDTH=3, with a flush input.

Test Plan:
- Reset low, busy held 1 for 65 cycles then 0; push 4 -> no cmd_valid while busy=1. cmd_valid pulses once with cmd=4 on the first cycle busy=0 is seen; issued_cnt=1.
- Push 1,2,3,4,5,6,7,0 back-to-back with a controller model (1-cycle busy for 1-7, 64-cycle busy then done for 0):
  - cmd_valid pulses in order;
  - cmd is stable throughout each busy period;
  - issued_cnt=8, image_done=1, host_ready=0 afterwards.
- Push 9 commands with busy held 1 -> host_ready falls after the 8th push; fifo_count=8; the 9th is not accepted.
- Push 0,5,5 -> only 0 is issued; after done, fifo_count=0, image_done=1; later host_valid pushes are ignored.
- Issue 3, then hold busy=1 for 130 cycles -> err=1 at cycle 127 of WAIT_LO. Deassert busy, push 4 -> cmd 4 is issued normally.
- Drop reset to 0 during the WAIT_LO of a cmd=0 -> all outputs return to reset values asynchronously, within the same cycle.
